// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory controller.
//   dm_state_e : controller state (INIT = clear sweep / bring-up, RUN = operational)
//   be_merge   : per-byte-lane write merge used by the storage array
package data_mem_pkg;

    typedef enum logic {
        INIT,
        RUN
    } dm_state_e;

    // Returns the new byte when its lane enable is set, otherwise keeps the old byte.
    function automatic logic [7:0] be_merge(input logic [7:0] old_val,
                                            input logic [7:0] new_val,
                                            input logic       be);
        return be ? new_val : old_val;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the data memory controller.
//   req_valid/req_ready          : request handshake
//   req_we/req_addr/req_wdata/req_be : request payload (write enable, word address, data, byte enables)
//   rsp_valid/rsp_ready          : response handshake
//   rsp_rdata/rsp_err            : response payload
//   init_done                    : memory operational after the clear sweep
// master = load/store stage, slave = data_mem_ctrl.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  init_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W single-port storage with byte-lane write and registered read.
//   clk   : clock
//   we    : write enable (lanes selected by be)
//   re    : read enable; rdata updates only on a read and holds otherwise
//   addr  : word index shared by read and write
//   wdata : write data
//   be    : byte enables, bit i covers bits [8i+7:8i]
//   rdata : registered read data
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [IDX_W-1:0]    addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                mem[addr][8*i +: 8] <= be_merge(mem[addr][8*i +: 8], wdata[8*i +: 8], be[i]);
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with valid/ready request/response bus.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : data_mem_ctrl_if slave (request, response, init_done)
// After reset an optional sweep zeroes every word; requests are refused until it
// completes. One response per accepted request, one cycle later; addresses at or
// beyond DEPTH return rsp_err=1 with zero data and never touch the array.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 2**ADDR_W,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    data_mem_ctrl_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LANES = DATA_W / 8;

    dm_state_e          state, state_next;
    logic [CNT_W-1:0]   clr_cnt;
    logic               sweep_last;
    logic               init_done;
    logic               req_ready;
    logic               accept;
    logic               in_range;
    logic               rsp_valid;
    logic               rsp_err;
    logic               rsp_is_read;

    logic               arr_we;
    logic               arr_re;
    logic [IDX_W-1:0]   arr_addr;
    logic [DATA_W-1:0]  arr_wdata;
    logic [LANES-1:0]   arr_be;
    logic [DATA_W-1:0]  arr_rdata;

    assign init_done  = (state == RUN);
    assign req_ready  = init_done & (~rsp_valid | bus.rsp_ready);
    assign accept     = bus.req_valid & req_ready;
    assign in_range   = {1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH);
    assign sweep_last = (clr_cnt == CNT_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT: if (CLEAR_ON_RESET == 0 || sweep_last) state_next = RUN;
            RUN:  state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state == INIT) begin
            clr_cnt <= clr_cnt + CNT_W'(1);
        end
    end

    // The single array port belongs to the clear sweep during INIT and to the bus in RUN.
    always_comb begin
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_addr  = bus.req_addr[IDX_W-1:0];
        arr_wdata = bus.req_wdata;
        arr_be    = bus.req_be;
        if (state == INIT) begin
            arr_we    = (CLEAR_ON_RESET != 0);
            arr_addr  = clr_cnt[IDX_W-1:0];
            arr_wdata = '0;
            arr_be    = '1;
        end else begin
            arr_we = accept &  bus.req_we & in_range;
            arr_re = accept & ~bus.req_we & in_range;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (arr_we),
        .re     (arr_re),
        .addr   (arr_addr),
        .wdata  (arr_wdata),
        .be     (arr_be),
        .rdata  (arr_rdata)
    );

    // The array's read register is the response data store; rsp_is_read masks it to
    // zero for writes, errors and after reset, so no second DATA_W register is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_is_read <= 1'b0;
        end else if (accept) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= ~in_range;
            rsp_is_read <= ~bus.req_we & in_range;
        end else if (bus.rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_err   = rsp_err;
    assign bus.rsp_rdata = rsp_is_read ? arr_rdata : '0;
    assign bus.init_done = init_done;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: two instances (DEPTH=16 and DEPTH=200, both clearing
// on reset) checked cycle by cycle against a transaction-level memory model.
module tb_data_mem_ctrl;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int NDUT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             req_valid [NDUT];
    logic             req_we    [NDUT];
    logic             rsp_ready [NDUT];
    logic [AW-1:0]    req_addr  [NDUT];
    logic [DW-1:0]    req_wdata [NDUT];
    logic [3:0]       req_be    [NDUT];

    logic [NDUT-1:0]  req_ready_o;
    logic [NDUT-1:0]  rsp_valid_o;
    logic [NDUT-1:0]  rsp_err_o;
    logic [NDUT-1:0]  init_done_o;
    logic [DW-1:0]    rsp_rdata_o [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

        assign bus.req_valid = req_valid[g];
        assign bus.req_we    = req_we[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.req_wdata = req_wdata[g];
        assign bus.req_be    = req_be[g];
        assign bus.rsp_ready = rsp_ready[g];

        assign req_ready_o[g] = bus.req_ready;
        assign rsp_valid_o[g] = bus.rsp_valid;
        assign rsp_err_o[g]   = bus.rsp_err;
        assign init_done_o[g] = bus.init_done;
        assign rsp_rdata_o[g] = bus.rsp_rdata;

        data_mem_ctrl #(
            .ADDR_W         (AW),
            .DATA_W         (DW),
            .DEPTH          ((g == 0) ? 16 : 200),
            .CLEAR_ON_RESET (1)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    function automatic int depth_of(input int d);
        return (d == 0) ? 16 : 200;
    endfunction

    // Reference model: memory contents plus the one outstanding response per instance.
    logic [DW-1:0] m_mem   [NDUT][256];
    bit            m_pend  [NDUT];
    bit            m_init  [NDUT];
    bit            m_err   [NDUT];
    logic [DW-1:0] m_rdata [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare outputs with the model, then advance the model over the coming clock edge.
    task automatic cycle_model(input int d, output bit acc);
        bit exp_ready;
        int a;
        exp_ready = m_init[d] && (!m_pend[d] || rsp_ready[d]);
        acc = 1'b0;
        check($sformatf("d%0d_req_ready", d), DW'(req_ready_o[d]), DW'(exp_ready));
        check($sformatf("d%0d_init_done", d), DW'(init_done_o[d]), DW'(m_init[d]));
        check($sformatf("d%0d_rsp_valid", d), DW'(rsp_valid_o[d]), DW'(m_pend[d]));
        if (m_pend[d]) begin
            check($sformatf("d%0d_rsp_rdata", d), rsp_rdata_o[d], m_rdata[d]);
            check($sformatf("d%0d_rsp_err", d), DW'(rsp_err_o[d]), DW'(m_err[d]));
        end
        if (req_valid[d] && exp_ready) begin
            acc = 1'b1;
            a = int'(req_addr[d]);
            if (a >= depth_of(d)) begin
                m_err[d]   = 1'b1;
                m_rdata[d] = '0;
            end else if (req_we[d]) begin
                for (int i = 0; i < 4; i++)
                    if (req_be[d][i]) m_mem[d][a][8*i +: 8] = req_wdata[d][8*i +: 8];
                m_err[d]   = 1'b0;
                m_rdata[d] = '0;
            end else begin
                m_err[d]   = 1'b0;
                m_rdata[d] = m_mem[d][a];
            end
            m_pend[d] = 1'b1;
        end else if (m_pend[d] && rsp_ready[d]) begin
            m_pend[d] = 1'b0;
        end
    endtask

    // One clock cycle, entered and left at a falling edge; the unselected instance idles.
    task automatic step(input int sel, input bit vld, input bit we, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input bit rready,
                        output bit acc);
        bit a_d;
        acc = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            if (d == sel) begin
                req_valid[d] = vld;
                req_we[d]    = we;
                req_addr[d]  = addr;
                req_wdata[d] = wdata;
                req_be[d]    = be;
                rsp_ready[d] = rready;
            end else begin
                req_valid[d] = 1'b0;
                rsp_ready[d] = 1'b1;
            end
        end
        #1;
        for (int d = 0; d < NDUT; d++) begin
            cycle_model(d, a_d);
            if (d == sel) acc = a_d;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset at a falling edge, then follows the clear sweep to completion.
    task automatic do_reset();
        bit done;
        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
        end
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_rst_rsp_valid", d), DW'(rsp_valid_o[d]), '0);
            check($sformatf("d%0d_rst_rsp_rdata", d), rsp_rdata_o[d], '0);
            check($sformatf("d%0d_rst_init_done", d), DW'(init_done_o[d]), '0);
            m_pend[d] = 1'b0;
            m_init[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 200; k++) begin
            #1;
            for (int d = 0; d < NDUT; d++) begin
                done = (k >= depth_of(d));
                check($sformatf("d%0d_sweep_init_done_k%0d", d, k), DW'(init_done_o[d]), DW'(done));
                check($sformatf("d%0d_sweep_req_ready_k%0d", d, k), DW'(req_ready_o[d]), DW'(done));
            end
            @(posedge clk);
            @(negedge clk);
        end
        for (int d = 0; d < NDUT; d++) begin
            m_init[d] = 1'b1;
            for (int a = 0; a < 256; a++) m_mem[d][a] = '0;
        end
    endtask

    initial begin
        bit          acc, hold, vld, we, rr;
        logic [7:0]  ad;
        logic [31:0] wd;
        logic [3:0]  be;

        for (int d = 0; d < NDUT; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_be[d]    = '0;
            rsp_ready[d] = 1'b1;
            m_pend[d]    = 1'b0;
            m_init[d]    = 1'b0;
            m_err[d]     = 1'b0;
            m_rdata[d]   = '0;
        end

        @(negedge clk);
        do_reset();

        // Every word reads zero after the sweep (back-to-back reads).
        for (int a = 0; a < 16; a++) step(0, 1, 0, 8'(a), '0, '0, 1, acc);
        step(0, 0, 0, 0, '0, '0, 1, acc);

        // Full-word write, then read back.
        step(0, 1, 1, 8'h00, 32'hAABBCCDD, 4'hF, 1, acc);
        check("t2_wr_rdata", rsp_rdata_o[0], '0);
        check("t2_wr_err", DW'(rsp_err_o[0]), '0);
        step(0, 1, 0, 8'h00, '0, '0, 1, acc);
        check("t2_rd_rdata", rsp_rdata_o[0], 32'hAABBCCDD);

        // Partial-lane write.
        step(0, 1, 1, 8'h00, 32'h11223344, 4'b0101, 1, acc);
        step(0, 1, 0, 8'h00, '0, '0, 1, acc);
        check("t3_rd_rdata", rsp_rdata_o[0], 32'hAA22CC44);

        // Zero byte-enable write is a no-op that still responds.
        step(0, 1, 1, 8'h00, 32'hFFFFFFFF, 4'h0, 1, acc);
        check("t3_be0_valid", DW'(rsp_valid_o[0]), 32'd1);
        step(0, 1, 0, 8'h00, '0, '0, 1, acc);
        check("t3_be0_rdata", rsp_rdata_o[0], 32'hAA22CC44);

        // Backpressure: response held, no acceptance, then accept on release.
        step(0, 1, 0, 8'h00, '0, '0, 0, acc);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 8'h05, 32'hDEADBEEF, 4'hF, 0, acc);
            check("t4_stall_acc", DW'(acc), '0);
            check("t4_stall_rdata", rsp_rdata_o[0], 32'hAA22CC44);
        end
        step(0, 1, 1, 8'h05, 32'hDEADBEEF, 4'hF, 1, acc);
        check("t4_release_acc", DW'(acc), 32'd1);
        check("t4_wr_rdata", rsp_rdata_o[0], '0);
        step(0, 1, 0, 8'h05, '0, '0, 1, acc);
        check("t4_rd_rdata", rsp_rdata_o[0], 32'hDEADBEEF);
        step(0, 0, 0, 0, '0, '0, 1, acc);

        // Range check on the DEPTH=200 instance.
        step(1, 1, 1, 8'hC7, 32'h12345678, 4'hF, 1, acc);
        step(1, 1, 1, 8'hC8, 32'hFFFFFFFF, 4'hF, 1, acc);
        check("t5_wr_err", DW'(rsp_err_o[1]), 32'd1);
        check("t5_wr_rdata", rsp_rdata_o[1], '0);
        step(1, 1, 0, 8'hC8, '0, '0, 1, acc);
        check("t5_rd_err", DW'(rsp_err_o[1]), 32'd1);
        check("t5_rd_rdata", rsp_rdata_o[1], '0);
        step(1, 1, 0, 8'hC7, '0, '0, 1, acc);
        check("t5_c7_err", DW'(rsp_err_o[1]), '0);
        check("t5_c7_rdata", rsp_rdata_o[1], 32'h12345678);
        step(1, 0, 0, 0, '0, '0, 1, acc);

        // Randomized traffic; an unaccepted request is held until taken.
        for (int d = 0; d < NDUT; d++) begin
            hold = 1'b0;
            vld  = 1'b0;
            we   = 1'b0;
            ad   = '0;
            wd   = '0;
            be   = '0;
            for (int n = 0; n < 500; n++) begin
                if (!hold) begin
                    vld = ($urandom_range(0, 3) != 0);
                    we  = $urandom_range(0, 1) == 1;
                    if (d == 0) ad = 8'($urandom_range(0, 20));
                    else if ($urandom_range(0, 3) == 0) ad = 8'($urandom_range(0, 255));
                    else ad = 8'($urandom_range(190, 210));
                    wd  = $urandom;
                    be  = 4'($urandom_range(0, 15));
                end
                rr = ($urandom_range(0, 3) != 0);
                step(d, vld, we, ad, wd, be, rr, acc);
                hold = vld && !acc;
            end
            step(d, 0, 0, 0, '0, '0, 1, acc);
        end

        // Reset while a response is pending; contents are cleared again.
        step(0, 1, 1, 8'h07, 32'hCAFEBABE, 4'hF, 1, acc);
        step(0, 1, 0, 8'h07, '0, '0, 0, acc);
        check("t6_pre_valid", DW'(rsp_valid_o[0]), 32'd1);
        do_reset();
        step(0, 1, 0, 8'h07, '0, '0, 1, acc);
        check("t6_rd_rdata", rsp_rdata_o[0], '0);
        step(1, 1, 0, 8'hC7, '0, '0, 1, acc);
        check("t6_c7_rdata", rsp_rdata_o[1], '0);
        step(1, 0, 0, 0, '0, '0, 1, acc);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
